// File: rtl/silife_max7219_pkg.sv
// Shared constants for the MAX7219-compatible serial receiver.
package silife_max7219_pkg;

   localparam int unsigned WORD_W = 16;

   typedef enum logic [3:0] {
      NOOP         = 4'h0,
      DIGIT0       = 4'h1,
      DIGIT1       = 4'h2,
      DIGIT2       = 4'h3,
      DIGIT3       = 4'h4,
      DIGIT4       = 4'h5,
      DIGIT5       = 4'h6,
      DIGIT6       = 4'h7,
      DIGIT7       = 4'h8,
      DECODE       = 4'h9,
      INTENSITY    = 4'hA,
      SCAN_LIMIT   = 4'hB,
      SHUTDOWN     = 4'hC,
      DISPLAY_TEST = 4'hF
   } reg_addr_e;

endpackage

// File: rtl/silife_sync.sv
// Multi-flop synchroniser with a configurable idle (reset) level.
module silife_sync #(
   parameter int unsigned STAGES = 2,
   parameter logic        IDLE   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (reset) ff <= {STAGES{IDLE}};
      else       ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/silife_max7219_rx.sv
// MAX7219 serial-protocol receiver: synchronises CS/SCK/MOSI, shifts 16-bit
// words and applies them to a register file mirroring the display driver.
module silife_max7219_rx
   import silife_max7219_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_cs,
   input  logic       i_sck,
   input  logic       i_mosi,
   output logic       o_dout,
   input  logic [2:0] i_row_select,
   output logic [7:0] o_row_data,
   output logic [7:0] o_decode_mode,
   output logic [3:0] o_intensity,
   output logic [2:0] o_scan_limit,
   output logic       o_shutdown,
   output logic       o_display_test,
   output logic       o_word_valid,
   output logic [3:0] o_addr,
   output logic [7:0] o_data,
   output logic       o_frame_error
);

   logic              cs_s, sck_s, mosi_s;
   logic              cs_d, sck_d;
   logic [WORD_W-1:0] shreg;
   logic [3:0]        bit_cnt;
   logic              seen16;
   logic [1:0]        settle;
   logic              armed;
   logic              latch_pend, err_pend;
   logic [7:0]        rows [8];
   logic              cs_rise, cs_fall, sck_rise, frame_ok;

   silife_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .d(i_cs), .q(cs_s));
   silife_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_sck (
      .clk(clk), .reset(reset), .d(i_sck), .q(sck_s));
   silife_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .d(i_mosi), .q(mosi_s));

   // Edges only count once the synchronisers hold real pin values and CS has
   // been seen high, so a frame already running at reset release is skipped.
   always_comb begin
      cs_rise  = armed & cs_s & ~cs_d;
      cs_fall  = armed & ~cs_s & cs_d;
      sck_rise = armed & ~cs_s & sck_s & ~sck_d;
      frame_ok = seen16 & (bit_cnt == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cs_d           <= 1'b1;
         sck_d          <= 1'b0;
         shreg          <= '0;
         bit_cnt        <= '0;
         seen16         <= 1'b0;
         settle         <= '0;
         armed          <= 1'b0;
         latch_pend     <= 1'b0;
         err_pend       <= 1'b0;
         o_word_valid   <= 1'b0;
         o_frame_error  <= 1'b0;
         o_addr         <= '0;
         o_data         <= '0;
         o_decode_mode  <= '0;
         o_intensity    <= '0;
         o_scan_limit   <= '0;
         o_shutdown     <= 1'b1;
         o_display_test <= 1'b0;
         for (int unsigned i = 0; i < 8; i++) rows[i] <= '0;
      end else begin
         cs_d          <= cs_s;
         sck_d         <= sck_s;
         latch_pend    <= cs_rise & frame_ok;
         err_pend      <= cs_rise & ~frame_ok;
         o_word_valid  <= latch_pend;
         o_frame_error <= err_pend;

         if (settle != 2'(SYNC_STAGES)) settle <= settle + 2'd1;
         else if (cs_s)                 armed  <= 1'b1;

         if (cs_fall) begin
            bit_cnt <= '0;
            seen16  <= 1'b0;
         end else if (sck_rise) begin
            shreg   <= {shreg[WORD_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'hF) seen16 <= 1'b1;
         end

         // CS is high while the word is pending, so shreg is stable here.
         if (latch_pend) begin
            o_addr <= shreg[11:8];
            o_data <= shreg[7:0];
            case (shreg[11:8])
               DIGIT0, DIGIT1, DIGIT2, DIGIT3,
               DIGIT4, DIGIT5, DIGIT6, DIGIT7:
                  rows[3'(shreg[11:8] - 4'd1)] <= shreg[7:0];
               DECODE:       o_decode_mode  <= shreg[7:0];
               INTENSITY:    o_intensity    <= shreg[3:0];
               SCAN_LIMIT:   o_scan_limit   <= shreg[2:0];
               SHUTDOWN:     o_shutdown     <= ~shreg[0];
               DISPLAY_TEST: o_display_test <= shreg[0];
               default: ;
            endcase
         end
      end
   end

   assign o_dout     = shreg[WORD_W-1];
   assign o_row_data = rows[i_row_select];

endmodule

// File: tb/tb_silife_max7219_rx.sv
// Scoreboard bench for silife_max7219_rx: bit-banged frames, model registers.
module tb_silife_max7219_rx;

   localparam int unsigned SS = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_cs = 1'b1, i_sck = 1'b0, i_mosi = 1'b0;
   logic [2:0] i_row_select = '0;
   logic       o_dout, o_shutdown, o_display_test, o_word_valid, o_frame_error;
   logic [7:0] o_row_data, o_decode_mode, o_data;
   logic [3:0] o_intensity, o_addr;
   logic [2:0] o_scan_limit;

   silife_max7219_rx #(.SYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .i_cs(i_cs), .i_sck(i_sck), .i_mosi(i_mosi),
      .o_dout(o_dout), .i_row_select(i_row_select), .o_row_data(o_row_data),
      .o_decode_mode(o_decode_mode), .o_intensity(o_intensity),
      .o_scan_limit(o_scan_limit), .o_shutdown(o_shutdown),
      .o_display_test(o_display_test), .o_word_valid(o_word_valid),
      .o_addr(o_addr), .o_data(o_data), .o_frame_error(o_frame_error));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_err;
      logic [15:0] w;
      int          due;
   } exp_t;
   exp_t sb[$];

   logic [7:0] m_rows [8];
   logic [7:0] m_decode;
   logic [3:0] m_int;
   logic [2:0] m_scan;
   logic       m_shut, m_dt;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rows[i] = '0;
      m_decode = '0; m_int = '0; m_scan = '0; m_shut = 1'b1; m_dt = 1'b0;
   endtask

   task automatic model_write(input logic [15:0] w);
      logic [3:0] a;
      a = w[11:8];
      if (a >= 4'h1 && a <= 4'h8) m_rows[a - 4'h1] = w[7:0];
      else if (a == 4'h9) m_decode = w[7:0];
      else if (a == 4'hA) m_int    = w[3:0];
      else if (a == 4'hB) m_scan   = w[2:0];
      else if (a == 4'hC) m_shut   = ~w[0];
      else if (a == 4'hF) m_dt     = w[0];
   endtask

   task automatic check_regs();
      check("decode", 32'(o_decode_mode), 32'(m_decode));
      check("intensity", 32'(o_intensity), 32'(m_int));
      check("scan_limit", 32'(o_scan_limit), 32'(m_scan));
      check("shutdown", 32'(o_shutdown), 32'(m_shut));
      check("display_test", 32'(o_display_test), 32'(m_dt));
      for (int r = 0; r < 8; r++) begin
         i_row_select = 3'(r);
         #1;
         check($sformatf("row%0d", r), 32'(o_row_data), 32'(m_rows[r]));
      end
   endtask

   task automatic sck_bit(input logic b);
      i_mosi = b;
      clks(4);
      i_sck = 1'b1;
      clks(4);
      i_sck = 1'b0;
   endtask

   // Frame of n bits, MSB first; o_dout must replay the bit sent 16 shifts ago.
   task automatic send(input logic [31:0] bits, input int n);
      exp_t e;
      i_cs = 1'b0;
      clks(4);
      for (int k = 0; k < n; k++) begin
         i_mosi = bits[n - 1 - k];
         clks(4);
         i_sck = 1'b1;
         clks(4);
         if (k >= 15) check("dout", 32'(o_dout), 32'(bits[n + 14 - k]));
         i_sck = 1'b0;
      end
      clks(4);
      i_cs = 1'b1;
      e.due = cyc + int'(SS) + 2;
      e.w   = bits[15:0];
      if (n > 0 && (n % 16) == 0) begin
         e.is_err = 1'b0;
         model_write(bits[15:0]);
      end else begin
         e.is_err = 1'b1;
      end
      sb.push_back(e);
      clks(14);
      check("sb_drained", 32'(sb.size()), 32'd0);
      check_regs();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && (o_word_valid === 1'b1 || o_frame_error === 1'b1)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {30'd0, o_word_valid, o_frame_error}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_kind", {30'd0, o_word_valid, o_frame_error},
                  e.is_err ? 32'd1 : 32'd2);
            check("latency", 32'(cyc), 32'(e.due));
            if (!e.is_err) begin
               check("addr", 32'(o_addr), 32'(e.w[11:8]));
               check("data", 32'(o_data), 32'(e.w[7:0]));
            end
         end
      end
   end

   initial begin
      logic [15:0] pw;
      model_reset();
      clks(5);
      check("rst_dout", 32'(o_dout), 32'd0);
      check("rst_valid", 32'(o_word_valid), 32'd0);
      check("rst_ferr", 32'(o_frame_error), 32'd0);
      check("rst_addr", 32'(o_addr), 32'd0);
      check("rst_data", 32'(o_data), 32'd0);
      check_regs();
      reset = 1'b0;
      clks(6);

      send(32'h0000_0A05, 16);
      send(32'h0000_0C01, 16);
      send(32'h0000_03A5, 16);
      send(32'h0000_0ABC, 12);
      send(32'h0001_2345, 20);
      send(32'h01FF_0B07, 32);
      send(32'h0000_0000, 0);
      send(32'h0000_59AA, 16);
      send(32'h0000_0D55, 16);
      send(32'h0000_0E66, 16);
      send(32'h0000_0077, 16);
      send(32'h0000_0883, 16);
      send(32'h0000_0AF3, 16);
      send(32'h0000_0BFD, 16);
      send(32'h0000_0C00, 16);

      // Reset in the middle of 0x0F01, then finish the frame: nothing may land.
      pw = 16'h0F01;
      i_cs = 1'b0;
      clks(4);
      for (int k = 15; k >= 8; k--) sck_bit(pw[k]);
      reset = 1'b1;
      clks(3);
      model_reset();
      reset = 1'b0;
      for (int k = 7; k >= 0; k--) sck_bit(pw[k]);
      clks(4);
      i_cs = 1'b1;
      clks(14);
      check("partial_sb", 32'(sb.size()), 32'd0);
      check_regs();
      send(32'h0000_0F01, 16);
      send(32'h0000_0123, 16);

      clks(10);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/silife_max7219_rx.md
SILIFE_MAX7219_RX -- requirements
Module: silife_max7219_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth on i_cs, i_sck and i_mosi; legal range 2..3.
REQ-002 clk  in  1  single system clock; all logic is on its rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 i_cs  in  1  MAX7219 LOAD/CS; low = frame active; asynchronous to clk.
REQ-005 i_sck  in  1  serial clock; data is sampled on its rising edge; asynchronous.
REQ-006 i_mosi  in  1  serial data, MSB first; asynchronous.
REQ-007 o_dout  out  1  daisy-chain output, equal to the shift register MSB, registered.
REQ-008 i_row_select  in  3  digit register read index.
REQ-009 o_row_data  out  8  digit register [i_row_select], combinational read.
REQ-010 o_decode_mode  out  8  decode-mode register (addr 0x9).
REQ-011 o_intensity  out  4  intensity register (addr 0xA, data[3:0]).
REQ-012 o_scan_limit  out  3  scan-limit register (addr 0xB, data[2:0]).
REQ-013 o_shutdown  out  1  1 = shutdown; cleared by a write of 1 to addr 0xC bit0.
REQ-014 o_display_test  out  1  display-test flag (addr 0xF, data bit0).
REQ-015 o_word_valid  out  1  one-clk pulse when a word is latched.
REQ-016 o_addr  out  4  address of the last latched word (word[11:8]).
REQ-017 o_data  out  8  data of the last latched word (word[7:0]).
REQ-018 o_frame_error  out  1  one-clk pulse when i_cs rises on a malformed frame.

Function
REQ-019 The block SHALL pass i_cs, i_sck and i_mosi through SYNC_STAGES flip-flops, then detect edges against one further registered copy.
REQ-020 The block SHALL receive correctly when each i_sck phase is at least SYNC_STAGES+1 clk periods long and i_mosi is stable across the i_sck rising edge.
REQ-021 On each synchronised i_sck rising edge while synchronised i_cs is low, the block SHALL left-shift sync i_mosi into a 16-bit shift register.
REQ-022 On each such edge, the block SHALL increment a 4-bit bit counter modulo 16 and set a "seen16" flag when the counter wraps from 15 to 0.
REQ-023 i_sck edges while i_cs is high SHALL be ignored.
REQ-024 A synchronised i_cs falling edge SHALL clear the bit counter and seen16; the shift register contents are retained.
REQ-025 On a synchronised i_cs rising edge with counter==0 and seen16==1, the block SHALL latch the word in the following clk:
- word[15:0] = the last 16 bits shifted in, which makes a daisy-chained frame of 16*N bits deliver its final 16 bits;
- o_word_valid = 1 for one clk;
- o_addr and o_data update;
- the register write is applied in the same clk.
REQ-026 Any other i_cs rising edge, including zero bits or a count that is not a multiple of 16, SHALL pulse o_frame_error for one clk and write nothing.
REQ-027 Register writes SHALL decode word[11:8] as follows:
- 0x0: no-op; o_word_valid still pulses;
- 0x1..0x8: digit rows 0..7;
- 0x9: decode mode;
- 0xA: intensity;
- 0xB: scan limit;
- 0xC: o_shutdown = ~data[0];
- 0xF: display test;
- 0xD, 0xE: ignored.
REQ-028 word[15:12] SHALL be don't-care.
REQ-029 Latency SHALL be fixed: from the i_cs rising edge at the input pin to the o_word_valid pulse is SYNC_STAGES+2 clk.
REQ-030 o_dout SHALL equal shift register bit 15, updated in the same clk as the shift, so that a downstream receiver sees the data delayed by 16 sck cycles.

Reset
REQ-031 While reset is high, the following SHALL be cleared:
- synchronisers to the idle state (cs=1, sck=0, mosi=0);
- shift register, counter and seen16;
- digit rows, decode, intensity, scan limit and display test;
- o_addr and o_data;
- o_dout, o_word_valid and o_frame_error.
REQ-032 While reset is high, o_shutdown SHALL be set to 1.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame.
REQ-034 After reset releases, a frame already in progress (i_cs low) SHALL be ignored until the next i_cs falling edge, because the synchronised idle state masks it.

Structure
REQ-035 Package silife_max7219_pkg SHALL hold the register address constants (NOOP, DIGIT0..7, DECODE, INTENSITY, SCAN_LIMIT, SHUTDOWN, DISPLAY_TEST).
REQ-036 silife_max7219_pkg SHALL also hold the 16-bit word width constant, shared with silife_max7219.
REQ-037 The block SHALL instantiate one sub-module, silife_sync (parameterised-depth synchroniser with idle-value parameter), three times.

Verification
REQ-038 Word 0x0A05 with sck phase of 4 clk -> o_intensity=5, o_addr=0xA, o_data=0x05, o_word_valid exactly once, SYNC_STAGES+2 clk after i_cs rises.
REQ-039 Words 0x0C01 then 0x03A5 -> o_shutdown 1->0; i_row_select=2 reads 0xA5; other rows remain 0x00.
REQ-040 A 12-bit frame, then a 20-bit frame -> o_frame_error pulses twice; all registers unchanged.
REQ-041 A 32-bit frame 0x01FF_0B07 -> only o_scan_limit=7 and row0 unchanged; o_dout shows the bits of 0x01FF, each delayed by 16 sck cycles.
REQ-042 Reset asserted after 8 bits of 0x0F01 -> o_display_test stays 0 and no pulse occurs; the next full frame 0x0F01 sets o_display_test=1.
REQ-043 Loopback: drive silife_max7219 (i_enable=1) into this block -> the intensity, scan limit and shutdown registers and all 8 digit rows match the driver's programmed values and i_cells rows.
